// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the decode/issue slice.
//   - opcode_e   : 4-bit opcode encoding (OP_CPT .. OP_LUI, OP_RSV0/1)
//   - REG_W      : register / operand width
//   - IDX_W      : register index width
//   - field slice constants for the 9-bit instruction word
package isa_pkg;

   localparam int unsigned REG_W   = 8;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned INSTR_W = 9;

   // Instruction fields: [8:5] opcode, [4:0] operand field, [2:0] rs.
   localparam int unsigned OPC_HI = 8;
   localparam int unsigned OPC_LO = 5;
   localparam int unsigned IMM_HI = 4;
   localparam int unsigned RS_HI  = 2;

   typedef enum logic [3:0] {
      OP_CPT  = 4'h0,
      OP_CPF  = 4'h1,
      OP_ADD  = 4'h2,
      OP_NOT  = 4'h3,
      OP_AND  = 4'h4,
      OP_LDR  = 4'h5,
      OP_STR  = 4'h6,
      OP_STL  = 4'h7,
      OP_XOR  = 4'h8,
      OP_LT   = 4'h9,
      OP_SHL  = 4'hA,
      OP_SHR  = 4'hB,
      OP_ADDI = 4'hC,
      OP_LUI  = 4'hD,
      OP_RSV0 = 4'hE,
      OP_RSV1 = 4'hF
   } opcode_e;

endpackage

// File: rtl/reg_file.sv
// reg_file: NREG x REG_W register file.
//   clk, rst_n       : clock, asynchronous active-low reset (clears all registers)
//   raddr0 / rdata0  : combinational read port 0
//   raddr1 / rdata1  : combinational read port 1
//   we, waddr, wdata : synchronous write port; a same-cycle write is bypassed to both reads
module reg_file
   import isa_pkg::*;
#(
   parameter int unsigned NREG = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] raddr0,
   output logic [REG_W-1:0] rdata0,
   input  logic [IDX_W-1:0] raddr1,
   output logic [REG_W-1:0] rdata1,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [REG_W-1:0] wdata
);

   logic [REG_W-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata0 = (we && (waddr == raddr0)) ? wdata : regs[raddr0];
      rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
   end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode-and-issue stage feeding the 8-bit ALU.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid, in_instr, in_ready : fetch handshake (9-bit instruction)
//   sign_mode                  : sampled at accept, presented as out_sign
//   wb_en, wb_addr, wb_data    : write-back port (register write + scoreboard clear)
//   out_valid, out_ready       : one-deep output register handshake
//   out_opcode, out_input0, out_input1, out_sign, out_dest, out_wr_en : ALU operands
//   illegal_op                 : one-cycle pulse after a reserved opcode is dropped
module decode_issue
   import isa_pkg::*;
#(
   parameter int unsigned NREG = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               in_ready,
   input  logic               sign_mode,
   input  logic               wb_en,
   input  logic [IDX_W-1:0]   wb_addr,
   input  logic [REG_W-1:0]   wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         out_opcode,
   output logic [REG_W-1:0]   out_input0,
   output logic [REG_W-1:0]   out_input1,
   output logic               out_sign,
   output logic [IDX_W-1:0]   out_dest,
   output logic               out_wr_en,
   output logic               illegal_op
);

   localparam logic [IDX_W-1:0] ACC = '0;  // R0, the accumulator

   opcode_e          opc;
   logic [IDX_W-1:0] rs;
   logic [4:0]       imm;
   logic [REG_W-1:0] r0_val, rs_val;

   assign opc = opcode_e'(in_instr[OPC_HI:OPC_LO]);
   assign rs  = in_instr[RS_HI:0];
   assign imm = in_instr[IMM_HI:0];

   reg_file #(
      .NREG (NREG)
   ) u_rf (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr0 (ACC),
      .rdata0 (r0_val),
      .raddr1 (rs),
      .rdata1 (rs_val),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data)
   );

   // Decode
   logic             use_r0, use_rs, dec_wr, dec_legal;
   logic [IDX_W-1:0] dec_dest;
   logic [REG_W-1:0] dec_in0, dec_in1;

   always_comb begin
      use_r0    = 1'b0;
      use_rs    = 1'b0;
      dec_wr    = 1'b1;
      dec_legal = 1'b1;
      dec_dest  = ACC;
      dec_in0   = '0;
      dec_in1   = '0;
      unique case (opc)
         OP_CPT: begin
            use_r0   = 1'b1;
            dec_in0  = r0_val;
            dec_dest = rs;
         end
         OP_CPF, OP_NOT, OP_LDR: begin
            use_rs  = 1'b1;
            dec_in0 = rs_val;
         end
         OP_STR, OP_STL: begin
            // R0 holds the address, so it still counts as a source for hazards.
            use_r0  = 1'b1;
            use_rs  = 1'b1;
            dec_wr  = 1'b0;
            dec_in0 = rs_val;
         end
         OP_ADD, OP_AND, OP_XOR: begin
            use_r0  = 1'b1;
            use_rs  = 1'b1;
            dec_in0 = r0_val;
            dec_in1 = rs_val;
         end
         OP_LT: begin
            use_r0  = 1'b1;
            use_rs  = 1'b1;
            dec_wr  = 1'b0;
            dec_in0 = r0_val;
            dec_in1 = rs_val;
         end
         OP_SHL, OP_SHR: begin
            use_r0  = 1'b1;
            dec_in0 = r0_val;
            dec_in1 = {3'b000, imm};
         end
         OP_ADDI: begin
            use_r0  = 1'b1;
            dec_in0 = r0_val;
            dec_in1 = {{3{imm[4]}}, imm};
         end
         OP_LUI: begin
            dec_in0 = {4'b0000, imm[3:0]};
         end
         OP_RSV0, OP_RSV1: begin
            dec_wr    = 1'b0;
            dec_legal = 1'b0;
         end
      endcase
   end

   // Scoreboard: a write-back this cycle releases its register immediately.
   logic [NREG-1:0] pend_q, pend_d, clr_mask, set_mask, pend_eff;
   logic            hazard, accept, issue;

   always_comb begin
      for (int i = 0; i < int'(NREG); i++) begin
         clr_mask[i] = wb_en && (wb_addr == IDX_W'(i));
         set_mask[i] = issue && dec_wr && (dec_dest == IDX_W'(i));
      end
   end

   assign pend_eff = pend_q & ~clr_mask;
   assign hazard   = (use_r0 && pend_eff[ACC]) || (use_rs && pend_eff[rs]) ||
                     (dec_wr && pend_eff[dec_dest]);
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;
   assign issue    = accept && dec_legal;
   // Set after clear so a same-cycle set of the same bit wins.
   assign pend_d   = (pend_q & ~clr_mask) | set_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_opcode <= '0;
         out_input0 <= '0;
         out_input1 <= '0;
         out_sign   <= 1'b0;
         out_dest   <= '0;
         out_wr_en  <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= accept && !dec_legal;
         if (issue) begin
            out_valid  <= 1'b1;
            out_opcode <= in_instr[OPC_HI:OPC_LO];
            out_input0 <= dec_in0;
            out_input1 <= dec_in1;
            out_sign   <= sign_mode;
            out_dest   <= dec_dest;
            out_wr_en  <= dec_wr;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_decode_issue.sv
module tb_decode_issue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [8:0] in_instr;
   logic       in_ready;
   logic       sign_mode;
   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_opcode;
   logic [7:0] out_input0, out_input1;
   logic       out_sign;
   logic [2:0] out_dest;
   logic       out_wr_en;
   logic       illegal_op;

   always #5 clk = ~clk;

   decode_issue #(.NREG(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_ready   (in_ready),
      .sign_mode  (sign_mode),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_input0 (out_input0),
      .out_input1 (out_input1),
      .out_sign   (out_sign),
      .out_dest   (out_dest),
      .out_wr_en  (out_wr_en),
      .illegal_op (illegal_op)
   );

   typedef struct packed {
      logic [3:0] opc;
      logic [7:0] in0;
      logic [7:0] in1;
      logic       sgn;
      logic [2:0] dest;
      logic       wr;
   } exp_t;

   exp_t       q[$];
   exp_t       e_mon;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] mregs [8];
   int         w;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference register file (write-back ignored in reset).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mregs[i] <= 8'h00;
      end else if (wb_en) begin
         mregs[wb_addr] <= wb_data;
      end
   end

   function automatic logic [7:0] rd(input logic [2:0] a);
      return (wb_en && wb_addr == a) ? wb_data : mregs[a];
   endfunction

   function automatic exp_t model(input logic [8:0] i, input logic s);
      exp_t       e;
      logic [2:0] r;
      r      = i[2:0];
      e.opc  = i[8:5];
      e.in0  = 8'h00;
      e.in1  = 8'h00;
      e.sgn  = s;
      e.dest = 3'd0;
      e.wr   = 1'b1;
      case (i[8:5])
         4'h0:             begin e.in0 = rd(3'd0); e.dest = r; end
         4'h1, 4'h3, 4'h5: e.in0 = rd(r);
         4'h6, 4'h7:       begin e.in0 = rd(r); e.wr = 1'b0; end
         4'h2, 4'h4, 4'h8: begin e.in0 = rd(3'd0); e.in1 = rd(r); end
         4'h9:             begin e.in0 = rd(3'd0); e.in1 = rd(r); e.wr = 1'b0; end
         4'hA, 4'hB:       begin e.in0 = rd(3'd0); e.in1 = {3'b000, i[4:0]}; end
         4'hC:             begin e.in0 = rd(3'd0); e.in1 = {{3{i[4]}}, i[4:0]}; end
         4'hD:             e.in0 = {4'h0, i[3:0]};
         default:          e.wr = 1'b0;
      endcase
      return e;
   endfunction

   // Offer one instruction until accepted; waits = stall cycles before accept.
   task automatic issue(input logic [8:0] i, input logic s, output int waits);
      bit done;
      done      = 1'b0;
      waits     = 0;
      in_valid  = 1'b1;
      in_instr  = i;
      sign_mode = s;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            if (i[8:5] < 4'hE) q.push_back(model(i, s));
            done = 1'b1;
         end else if (waits >= 20) begin
            check("issue_timeout", 32'd0, 32'd1);
            done = 1'b1;
         end else begin
            waits++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wb(input logic [2:0] a, input logic [7:0] d);
      wb_en   = 1'b1;
      wb_addr = a;
      wb_data = d;
      @(posedge clk);
      #1;
      wb_en = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_opc"}, {28'd0, out_opcode}, 32'd0);
      check({tag, "_in0"}, {24'd0, out_input0}, 32'd0);
      check({tag, "_in1"}, {24'd0, out_input1}, 32'd0);
      check({tag, "_sign"}, {31'd0, out_sign}, 32'd0);
      check({tag, "_dest"}, {29'd0, out_dest}, 32'd0);
      check({tag, "_wr"}, {31'd0, out_wr_en}, 32'd0);
      check({tag, "_ill"}, {31'd0, illegal_op}, 32'd0);
   endtask

   // Scoreboard consumer: compare on every output fire.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            e_mon = q.pop_front();
            check("out_opcode", {28'd0, out_opcode}, {28'd0, e_mon.opc});
            check("out_input0", {24'd0, out_input0}, {24'd0, e_mon.in0});
            check("out_input1", {24'd0, out_input1}, {24'd0, e_mon.in1});
            check("out_sign", {31'd0, out_sign}, {31'd0, e_mon.sgn});
            check("out_dest", {29'd0, out_dest}, {29'd0, e_mon.dest});
            check("out_wr_en", {31'd0, out_wr_en}, {31'd0, e_mon.wr});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 9'h000;
      sign_mode = 1'b0;
      wb_en     = 1'b0;
      wb_addr   = 3'd0;
      wb_data   = 8'h00;
      out_ready = 1'b1;
      #1;
      check_all_zero("rst");
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // add R0,R3 after R3 write-back; one-cycle latency
      wb(3'd3, 8'h5A);
      issue(9'b0010_00011, 1'b0, w);
      @(negedge clk);
      check("lat_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
      wb(3'd0, 8'h11);

      // addi -1, then RAW stall on R0 released by a same-cycle write-back
      issue(9'b1100_11111, 1'b1, w);
      in_valid  = 1'b1;
      in_instr  = 9'b0010_00000;
      sign_mode = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("raw_stall", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      wb_en   = 1'b1;
      wb_addr = 3'd0;
      wb_data = 8'h07;
      @(negedge clk);
      check("raw_release", {31'd0, in_ready}, 32'd1);
      q.push_back(model(9'b0010_00000, 1'b0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wb_en    = 1'b0;
      // set beat the same-cycle clear: R0 still pending
      in_valid = 1'b1;
      in_instr = 9'b0000_00101;
      @(negedge clk);
      check("set_wins", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wb(3'd0, 8'h20);

      // backpressure: xor held 3 cycles, lui waits
      issue(9'b1000_00011, 1'b0, w);
      out_ready = 1'b0;
      wb(3'd0, 8'h33);
      in_valid = 1'b1;
      in_instr = 9'b1101_00110;
      repeat (3) begin
         @(negedge clk);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_opc", {28'd0, out_opcode}, 32'h8);
         check("bp_in0", {24'd0, out_input0}, 32'h20);
         check("bp_in1", {24'd0, out_input1}, 32'h5A);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      issue(9'b1101_00110, 1'b0, w);
      check("bp_release_wait", w, 32'd0);
      wb(3'd0, 8'h44);

      // reserved opcode: dropped with a one-cycle pulse
      issue(9'b1110_00000, 1'b0, w);
      @(negedge clk);
      check("ill_pulse", {31'd0, illegal_op}, 32'd1);
      check("ill_no_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
      @(posedge clk);
      #1;

      // shl 3, then str R2 (no pend), then cpf must not stall
      issue(9'b1010_00011, 1'b0, w);
      wb(3'd0, 8'h55);
      wb(3'd2, 8'h42);
      issue(9'b0110_00010, 1'b0, w);
      issue(9'b0001_00010, 1'b1, w);
      check("str_no_pend", w, 32'd0);
      wb(3'd0, 8'h66);

      // back-to-back independent issues
      for (int k = 4; k < 7; k++) begin
         issue({4'h0, 2'b00, 3'(k)}, k[0], w);
         check("b2b_wait", w, 32'd0);
      end

      // async reset while stalled with out_valid=1
      issue(9'b1000_00011, 1'b0, w);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 9'b0000_00111;
      @(negedge clk);
      check("pre_rst_stall", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n   = 1'b0;
      wb_en   = 1'b1;
      wb_addr = 3'd3;
      wb_data = 8'hEE;
      #1;
      check_all_zero("midrst");
      q.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      wb_en     = 1'b0;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_instr  = 9'b0000_00111;
      @(negedge clk);
      check("post_rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      issue(9'b0010_00011, 1'b0, w);
      repeat (3) @(posedge clk);
      #1;

      check("q_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
